// File: rtl/mem_bridge.sv
// +----------------------------------------------------------------------------+
// | mem_bridge: serialises core inst-read / data-read / data-write requests    |
// | onto one single-port, variable-latency memory bus.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INST_RDEN,
  input  logic [31:0]           INST_RIADDR,
  output logic [31:0]           INST_ROADDR,
  output logic                  INST_RVALID,
  output logic [31:0]           INST_RDATA,
  input  logic                  DATA_RDEN,
  input  logic [31:0]           DATA_RIADDR,
  output logic [31:0]           DATA_ROADDR,
  output logic                  DATA_RVALID,
  output logic [31:0]           DATA_RDATA,
  input  logic                  DATA_WREN,
  input  logic [3:0]            DATA_WSTRB,
  input  logic [31:0]           DATA_WADDR,
  input  logic [31:0]           DATA_WDATA,
  output logic                  MEM_WAIT,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [3:0]            MEM_WSTRB,
  output logic [31:0]           MEM_WDATA,
  input  logic                  MEM_ACK,
  input  logic [31:0]           MEM_RDATA
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Pending / in-flight vector bit positions.
  localparam int unsigned C_INST = 0;
  localparam int unsigned C_DRD  = 1;
  localparam int unsigned C_WR   = 2;

  state_e                state_q, state_d;
  logic [2:0]            pend_q, pend_d;
  logic [2:0]            cur_q, cur_d;
  logic [31:0]           iaddr_q, iaddr_d;
  logic [31:0]           daddr_q, daddr_d;
  logic [31:0]           waddr_q, waddr_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  inst_rvalid_q, inst_rvalid_d;
  logic [31:0]           inst_roaddr_q, inst_roaddr_d;
  logic [31:0]           inst_rdata_q, inst_rdata_d;
  logic                  data_rvalid_q, data_rvalid_d;
  logic [31:0]           data_roaddr_q, data_roaddr_d;
  logic [31:0]           data_rdata_q, data_rdata_d;
  logic                  issue;
  logic [2:0]            sel;

  function automatic logic [2:0] pick(input logic [2:0] p);
    logic [2:0] r;
    r = 3'b000;
    if (WRITE_FIRST) begin
      if      (p[C_WR])   r = 3'b100;
      else if (p[C_DRD])  r = 3'b010;
      else if (p[C_INST]) r = 3'b001;
    end else begin
      if      (p[C_DRD])  r = 3'b010;
      else if (p[C_WR])   r = 3'b100;
      else if (p[C_INST]) r = 3'b001;
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    cur_d         = cur_q;
    iaddr_d       = iaddr_q;
    daddr_d       = daddr_q;
    waddr_d       = waddr_q;
    wstrb_d       = wstrb_q;
    wdata_d       = wdata_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    inst_rvalid_d = 1'b0;
    inst_roaddr_d = inst_roaddr_q;
    inst_rdata_d  = inst_rdata_q;
    data_rvalid_d = 1'b0;
    data_roaddr_d = data_roaddr_q;
    data_rdata_d  = data_rdata_q;
    issue         = 1'b0;
    sel           = 3'b000;

    if (pend_q == 3'b000) begin
      if (INST_RDEN) begin
        pend_d[C_INST] = 1'b1;
        iaddr_d        = INST_RIADDR;
      end
      if (DATA_RDEN) begin
        pend_d[C_DRD] = 1'b1;
        daddr_d       = DATA_RIADDR;
      end
      if (DATA_WREN) begin
        pend_d[C_WR] = 1'b1;
        waddr_d      = DATA_WADDR;
        wstrb_d      = DATA_WSTRB;
        wdata_d      = DATA_WDATA;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_d != 3'b000) issue = 1'b1;
      end
      ST_BUSY: begin
        if (MEM_ACK) begin
          pend_d = pend_d & ~cur_q;
          if (cur_q[C_INST]) begin
            inst_rvalid_d = 1'b1;
            inst_roaddr_d = iaddr_q;
            inst_rdata_d  = MEM_RDATA;
          end
          if (cur_q[C_DRD]) begin
            data_rvalid_d = 1'b1;
            data_roaddr_d = daddr_q;
            data_rdata_d  = MEM_RDATA;
          end
          if (pend_d != 3'b000) begin
            issue = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            cur_d     = 3'b000;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Issue uses the _d capture values so a fresh accept goes out next cycle.
    if (issue) begin
      sel         = pick(pend_d);
      state_d     = ST_BUSY;
      mem_req_d   = 1'b1;
      cur_d       = sel;
      mem_we_d    = sel[C_WR];
      mem_wstrb_d = sel[C_WR] ? wstrb_d : 4'h0;
      mem_wdata_d = sel[C_WR] ? wdata_d : 32'h0;
      if (sel[C_WR])       mem_addr_d = waddr_d[ADDR_WIDTH-1:0];
      else if (sel[C_DRD]) mem_addr_d = daddr_d[ADDR_WIDTH-1:0];
      else                 mem_addr_d = iaddr_d[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      pend_q        <= '0;
      cur_q         <= '0;
      iaddr_q       <= '0;
      daddr_q       <= '0;
      waddr_q       <= '0;
      wstrb_q       <= '0;
      wdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wstrb_q   <= '0;
      mem_wdata_q   <= '0;
      inst_rvalid_q <= 1'b0;
      inst_roaddr_q <= '0;
      inst_rdata_q  <= '0;
      data_rvalid_q <= 1'b0;
      data_roaddr_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      cur_q         <= cur_d;
      iaddr_q       <= iaddr_d;
      daddr_q       <= daddr_d;
      waddr_q       <= waddr_d;
      wstrb_q       <= wstrb_d;
      wdata_q       <= wdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
      inst_rvalid_q <= inst_rvalid_d;
      inst_roaddr_q <= inst_roaddr_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rvalid_q <= data_rvalid_d;
      data_roaddr_q <= data_roaddr_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign MEM_WAIT    = |pend_q;
  assign MEM_REQ     = mem_req_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WSTRB   = mem_wstrb_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign INST_RVALID = inst_rvalid_q;
  assign INST_ROADDR = inst_roaddr_q;
  assign INST_RDATA  = inst_rdata_q;
  assign DATA_RVALID = data_rvalid_q;
  assign DATA_ROADDR = data_roaddr_q;
  assign DATA_RDATA  = data_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bridge.sv
// +----------------------------------------------------------------------------+
// | tb_mem_bridge: scoreboard bench for mem_bridge with a queue-based model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_bridge;

  localparam int AW          = 32;
  localparam bit WRITE_FIRST = 1'b1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          INST_RDEN;
  logic [31:0]   INST_RIADDR;
  logic [31:0]   INST_ROADDR;
  logic          INST_RVALID;
  logic [31:0]   INST_RDATA;
  logic          DATA_RDEN;
  logic [31:0]   DATA_RIADDR;
  logic [31:0]   DATA_ROADDR;
  logic          DATA_RVALID;
  logic [31:0]   DATA_RDATA;
  logic          DATA_WREN;
  logic [3:0]    DATA_WSTRB;
  logic [31:0]   DATA_WADDR;
  logic [31:0]   DATA_WDATA;
  logic          MEM_WAIT;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_WSTRB;
  logic [31:0]   MEM_WDATA;
  logic          MEM_ACK;
  logic [31:0]   MEM_RDATA;

  always #5 CLK = ~CLK;

  mem_bridge #(.ADDR_WIDTH(AW), .WRITE_FIRST(WRITE_FIRST)) dut (
    .CLK(CLK), .RST(RST),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
    .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WSTRB(DATA_WSTRB), .DATA_WADDR(DATA_WADDR),
    .DATA_WDATA(DATA_WDATA),
    .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA)
  );

  // kind: 2 = write, 1 = data read, 0 = inst read
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } bus_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rd_t;

  bus_t        bus_q[$];
  rd_t         inst_q[$];
  rd_t         data_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] slave_mem [256];

  int n_vec  = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  bit exp_iv = 1'b0;
  bit exp_dv = 1'b0;

  bit   zero_wait = 1'b0;
  logic ack_r     = 1'b0;
  logic stray     = 1'b0;
  int   lat_mode  = -1;
  int   cnt       = 0;
  int   target    = 1;

  assign MEM_ACK   = zero_wait ? MEM_REQ : (ack_r | stray);
  assign MEM_RDATA = slave_mem[MEM_ADDR[9:2]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_note(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none", nm);
  endtask

  // Reference model: an accepted batch executes in priority order against a flat memory.
  task automatic model_issue(input bit w, input bit d, input bit i,
                             input logic [31:0] waddr, input logic [3:0] strb,
                             input logic [31:0] wdata, input logic [31:0] daddr,
                             input logic [31:0] iaddr);
    int   ord[3];
    bus_t eb;
    rd_t  er;
    if (WRITE_FIRST) ord = '{2, 1, 0};
    else             ord = '{1, 2, 0};
    for (int p = 0; p < 3; p++) begin
      if (ord[p] == 2 && w) begin
        eb = '{kind: 2, addr: waddr, strb: strb, data: wdata};
        bus_q.push_back(eb);
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[waddr[9:2]][8*b +: 8] = wdata[8*b +: 8];
      end
      if (ord[p] == 1 && d) begin
        eb = '{kind: 1, addr: daddr, strb: 4'h0, data: 32'h0};
        bus_q.push_back(eb);
        er = '{addr: daddr, data: model_mem[daddr[9:2]]};
        data_q.push_back(er);
      end
      if (ord[p] == 0 && i) begin
        eb = '{kind: 0, addr: iaddr, strb: 4'h0, data: 32'h0};
        bus_q.push_back(eb);
        er = '{addr: iaddr, data: model_mem[iaddr[9:2]]};
        inst_q.push_back(er);
      end
    end
  endtask

  task automatic drive_req(input bit w, input bit d, input bit i,
                           input logic [31:0] waddr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] daddr,
                           input logic [31:0] iaddr);
    DATA_WREN   = w;
    DATA_WADDR  = waddr;
    DATA_WSTRB  = strb;
    DATA_WDATA  = wdata;
    DATA_RDEN   = d;
    DATA_RIADDR = daddr;
    INST_RDEN   = i;
    INST_RIADDR = iaddr;
    model_issue(w, d, i, waddr, strb, wdata, daddr, iaddr);
  endtask

  task automatic idle_inputs();
    INST_RDEN = 1'b0;
    DATA_RDEN = 1'b0;
    DATA_WREN = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (MEM_WAIT !== 1'b0 && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    if (MEM_WAIT !== 1'b0) fail_note("wait_idle_timeout");
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h200 + ($urandom_range(0, 7) << 2);
  endfunction

  // Memory slave: acks after a programmable number of REQ cycles.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (zero_wait) begin
        ack_r = 1'b0;
        cnt   = 0;
      end else if (ack_r) begin
        ack_r  = 1'b0;
        cnt    = 0;
        target = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else if (MEM_REQ === 1'b1) begin
        if (cnt >= target) ack_r = 1'b1;
        else               cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations on every bus handshake and every RVALID.
  initial begin
    bus_t eb;
    rd_t  er;
    forever begin
      @(negedge CLK);
      if (INST_RVALID !== 1'b0 || exp_iv) begin
        check("inst_rvalid", INST_RVALID, exp_iv);
        if (INST_RVALID === 1'b1) begin
          if (inst_q.size() == 0) fail_note("inst_rvalid_extra");
          else begin
            er = inst_q.pop_front();
            check("inst_roaddr", INST_ROADDR, er.addr);
            check("inst_rdata", INST_RDATA, er.data);
          end
        end
      end
      if (DATA_RVALID !== 1'b0 || exp_dv) begin
        check("data_rvalid", DATA_RVALID, exp_dv);
        if (DATA_RVALID === 1'b1) begin
          if (data_q.size() == 0) fail_note("data_rvalid_extra");
          else begin
            er = data_q.pop_front();
            check("data_roaddr", DATA_ROADDR, er.addr);
            check("data_rdata", DATA_RDATA, er.data);
          end
        end
      end
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      if (MEM_REQ === 1'b1 && MEM_ACK === 1'b1) begin
        hs_cnt++;
        if (bus_q.size() == 0) fail_note("bus_extra_transfer");
        else begin
          eb = bus_q.pop_front();
          check("bus_we", MEM_WE, eb.kind == 2);
          check("bus_addr", MEM_ADDR, eb.addr);
          check("bus_wstrb", MEM_WSTRB, eb.strb);
          if (eb.kind == 2) check("bus_wdata", MEM_WDATA, eb.data);
          if (eb.kind == 1) exp_dv = 1'b1;
          if (eb.kind == 0) exp_iv = 1'b1;
        end
        if (MEM_WE === 1'b1)
          for (int b = 0; b < 4; b++)
            if (MEM_WSTRB[b]) slave_mem[MEM_ADDR[9:2]][8*b +: 8] = MEM_WDATA[8*b +: 8];
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, base, nreq, first, last;
    bit w, d, i;

    RST = 1'b1;
    idle_inputs();
    INST_RIADDR = '0; DATA_RIADDR = '0; DATA_WADDR = '0;
    DATA_WSTRB = '0; DATA_WDATA = '0;
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = 32'h1000_0000 + a;
      slave_mem[a] = 32'h1000_0000 + a;
    end
    model_mem[64] = 32'h0000_0013;
    slave_mem[64] = 32'h0000_0013;

    // Reset with MEM_ACK toggling
    repeat (2) begin @(posedge CLK); #1 stray = ~stray; end
    @(negedge CLK);
    check("rst_mem_req", MEM_REQ, 0);
    check("rst_mem_wait", MEM_WAIT, 0);
    check("rst_inst_rvalid", INST_RVALID, 0);
    check("rst_data_rvalid", DATA_RVALID, 0);
    check("rst_inst_roaddr", INST_ROADDR, 0);
    check("rst_inst_rdata", INST_RDATA, 0);
    check("rst_data_roaddr", DATA_ROADDR, 0);
    check("rst_data_rdata", DATA_RDATA, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    stray = 1'b0;
    lat_mode = 3;
    target = 3;

    // Single inst read, ACK three cycles after REQ
    @(posedge CLK); #1;
    drive_req(0, 0, 1, 0, 0, 0, 0, 32'h100);
    @(posedge CLK); #1;
    idle_inputs();
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      k = c;
      if (INST_RVALID === 1'b1) break;
      check("single_wait_high", MEM_WAIT, 1);
    end
    check("single_rvalid_latency", k, 5);
    check("single_wait_low_at_rvalid", MEM_WAIT, 0);
    @(negedge CLK);
    check("single_rvalid_pulse", INST_RVALID, 0);
    lat_mode = -1;

    // Triple request in one accept
    @(posedge CLK); #1;
    wait_idle();
    drive_req(1, 1, 1, 32'h200, 4'hF, 32'hDEADBEEF, 32'h200, 32'h0);
    base = hs_cnt;
    @(posedge CLK); #1;
    idle_inputs();
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (MEM_WAIT !== 1'b1) break;
    end
    check("triple_wait_span", hs_cnt - base, 3);
    check("triple_inst_last", INST_RVALID, 1);

    // Zero-wait ACK, two reads back-to-back
    @(posedge CLK); #1;
    zero_wait = 1'b1;
    @(posedge CLK); #1;
    drive_req(0, 1, 1, 0, 0, 0, 32'h204, 32'h208);
    @(posedge CLK); #1;
    idle_inputs();
    nreq = 0; first = -1; last = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (MEM_REQ === 1'b1) begin
        nreq++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("zw_req_cycles", nreq, 2);
    check("zw_req_first", first, 1);
    check("zw_req_last", last, 2);
    @(posedge CLK); #1;
    zero_wait = 1'b0;

    // Reset while a read is outstanding, late ACK afterwards
    lat_mode = 100;
    target = 100;
    @(posedge CLK); #1;
    drive_req(0, 1, 0, 0, 0, 0, 32'h20C, 0);
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    check("midrst_req_before", MEM_REQ, 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    bus_q.delete();
    data_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_req_after", MEM_REQ, 0);
    check("midrst_wait_after", MEM_WAIT, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    stray = 1'b1;
    @(posedge CLK); #1;
    stray = 1'b0;
    lat_mode = -1;
    target = 1;
    @(negedge CLK);
    check("late_ack_req", MEM_REQ, 0);
    check("late_ack_wait", MEM_WAIT, 0);
    check("late_ack_rvalid", DATA_RVALID, 0);

    // Stray ACK while idle
    @(posedge CLK); #1;
    stray = 1'b1;
    @(posedge CLK); #1;
    stray = 1'b0;
    @(negedge CLK);
    check("stray_req", MEM_REQ, 0);
    check("stray_wait", MEM_WAIT, 0);

    // Randomised traffic; garbage enables whenever MEM_WAIT is high
    for (int it = 0; it < 500; it++) begin
      @(posedge CLK); #1;
      if (MEM_WAIT === 1'b1) begin
        DATA_WREN   = 1'($urandom);
        DATA_RDEN   = 1'($urandom);
        INST_RDEN   = 1'($urandom);
        DATA_WADDR  = $urandom;
        DATA_WDATA  = $urandom;
        DATA_WSTRB  = 4'($urandom);
        DATA_RIADDR = $urandom;
        INST_RIADDR = $urandom;
      end else if ($urandom_range(0, 2) != 0) begin
        w = 1'($urandom);
        d = 1'($urandom);
        i = 1'($urandom);
        drive_req(w, d, i, rand_addr(), 4'($urandom), $urandom, rand_addr(), rand_addr());
      end else begin
        idle_inputs();
        if (MEM_REQ === 1'b0 && $urandom_range(0, 5) == 0) zero_wait = ~zero_wait;
      end
    end
    @(posedge CLK); #1;
    idle_inputs();
    wait_idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("drain_bus_q", bus_q.size(), 0);
    check("drain_inst_q", inst_q.size(), 0);
    check("drain_data_q", data_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
